// File: rtl/alu_mult_sequencer.sv
// Signed 32x32 radix-2 Booth multiplier sequencer that borrows a shared 32-bit ALU for 32 cycles.
// Optional macro MULT_SEQ_ZERO_BYPASS_EN: a start with a zero operand skips RUN and completes next cycle.
module alu_mult_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        q_q, q_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        zero_start;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    assign zero_start = (data_operandA == '0) || (data_operandB == '0);
`else
    assign zero_start = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            q_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        phi_d        = phi_q;
        plo_d        = plo_q;
        q_d          = q_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        exc_d        = exc_q;
        alu_operandA = '0;
        alu_operandB = '0;
        alu_opcode   = 5'b00000;

        case (state_q)
            IDLE: begin
                if (ctrl_MULT) begin
                    if (zero_start) begin
                        state_d = DONE;
                        res_d   = '0;
                        exc_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        m_d     = data_operandA;
                        phi_d   = '0;
                        plo_d   = data_operandB;
                        q_d     = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                alu_operandA = phi_q;
                case ({plo_q[0], q_q})
                    2'b01: alu_operandB = m_q;
                    2'b10: begin
                        alu_opcode   = 5'b00001;
                        alu_operandB = m_q;
                    end
                    default: alu_operandB = '0;
                endcase
                // Sign of the 33-bit true sum is result[31]^overflow; keeps M=-2^31 correct.
                phi_d = {alu_result[31] ^ alu_overflow, alu_result[31:1]};
                plo_d = {alu_result[0], plo_q[31:1]};
                q_d   = plo_q[0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_d == 6'd32) begin
                    state_d = DONE;
                    res_d   = plo_d;
                    exc_d   = (phi_d != {32{plo_d[31]}});
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign alu_shiftamt   = 5'b00000;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural add/subtract ALU attached to its ALU ports.
module tb_alu_mult_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic [4:0]  alu_opcode, alu_shiftamt;
    logic        alu_overflow;
    logic [31:0] alu_b_eff;

    int checks   = 0;
    int failures = 0;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    always #5 clock = ~clock;

    // Shared ALU: opcode 1 subtracts, anything else adds; signed overflow flag.
    assign alu_b_eff    = (alu_opcode == 5'd1) ? ~alu_operandB : alu_operandB;
    assign alu_result   = alu_operandA + alu_b_eff + {31'd0, (alu_opcode == 5'd1)};
    assign alu_overflow = (alu_operandA[31] == alu_b_eff[31]) && (alu_result[31] != alu_operandA[31]);

    alu_mult_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a start for one cycle; returns at the sample point of cycle N+1.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        tick();
        ctrl_MULT     = 1'b0;
    endtask

    // Called at cycle N+1; returns at the RDY cycle with its offset from N (80 on timeout).
    task automatic wait_rdy(output int lat, output logic busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (!data_resultRDY && lat < 80) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
        int   lat;
        logic bok;
        start(a, b);
        wait_rdy(lat, bok);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_busy"}, {31'd0, bok}, 32'd1);
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        tick();
        check({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   lat;
        logic bok;
        logic seen_rdy;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_op", {27'd0, alu_opcode}, 32'd0);
        check("rst_alu_a", alu_operandA, 32'd0);
        reset = 1'b0;
        tick();

        // 7 x -3: first RUN cycle sees Booth pair 10 -> subtract M from P_hi=0
        start(32'd7, 32'hFFFF_FFFD);
        check("run0_opcode", {27'd0, alu_opcode}, 32'd1);
        check("run0_alu_a", alu_operandA, 32'd0);
        check("run0_alu_b", alu_operandB, 32'd7);
        check("run0_shamt", {27'd0, alu_shiftamt}, 32'd0);
        wait_rdy(lat, bok);
        check("m7x-3_lat", lat, 33);
        check("m7x-3_busy", {31'd0, bok}, 32'd1);
        check("m7x-3_res", data_result, 32'hFFFF_FFEB);
        check("m7x-3_exc", {31'd0, data_exception}, 32'd0);
        tick();
        check("m7x-3_rdy_drop", {31'd0, data_resultRDY}, 32'd0);
        check("m7x-3_idle", {31'd0, busy}, 32'd0);
        check("idle_alu_b", alu_operandB, 32'd0);

        mult("min_x_m1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        mult("min_x_1",   32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        mult("2p16_sq",   32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1);
        mult("m1_x_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0);

        // Hold ctrl_MULT through RUN/DONE with new operands: only the first operands count,
        // and the held request is next accepted in cycle N+34 with the changed operands.
        data_operandA = 32'd9;
        data_operandB = 32'd11;
        ctrl_MULT     = 1'b1;
        tick();
        data_operandA = 32'd100;
        data_operandB = 32'd100;
        wait_rdy(lat, bok);
        check("hold_lat", lat, 33);
        check("hold_res", data_result, 32'd99);
        tick();
        check("hold_n34_idle", {31'd0, busy}, 32'd0);
        check("hold_n34_rdy", {31'd0, data_resultRDY}, 32'd0);
        tick();
        ctrl_MULT = 1'b0;
        check("hold_n35_busy", {31'd0, busy}, 32'd1);
        check("hold_res_held", data_result, 32'd99);
        wait_rdy(lat, bok);
        check("hold2_lat", lat, 33);
        check("hold2_res", data_result, 32'd10000);
        check("hold2_exc", {31'd0, data_exception}, 32'd0);
        tick();

        // Reset during cycle N+10 aborts the operation without a RDY pulse
        start(32'd123, 32'd456);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_res", data_result, 32'd0);
        check("mid_rst_exc", {31'd0, data_exception}, 32'd0);
        check("mid_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        seen_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY) seen_rdy = 1'b1;
        end
        check("mid_rst_no_rdy", {31'd0, seen_rdy}, 32'd0);
        mult("after_rst_5x6", 32'd5, 32'd6, 32'd30, 1'b0);

        // Zero operand: bypass latency when the feature is built in, full path otherwise
        start(32'd0, 32'd12345);
        wait_rdy(lat, bok);
        check("zero_lat", lat, ZERO_LAT);
        check("zero_res", data_result, 32'd0);
        check("zero_exc", {31'd0, data_exception}, 32'd0);
        tick();
        check("zero_rdy_drop", {31'd0, data_resultRDY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
